// File: rtl/dca_refill.sv
// Data-cache refill engine: writes back a dirty victim line word by word,
// fetches the missing line word by word, then returns it in one fill pulse.
module dca_refill #(
  parameter int REG_WIDTH  = 32,
  parameter int PA_WIDTH   = 32,
  parameter int LINE_WIDTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_miss,
  input  logic [PA_WIDTH-1:0]             i_miss_addr,
  input  logic                            i_evict_dirty,
  input  logic [PA_WIDTH-1:0]             i_evict_addr,
  input  logic [LINE_WIDTH*REG_WIDTH-1:0] i_evict_data,
  output logic                            o_stall,
  output logic                            o_mem_req,
  output logic                            o_mem_we,
  output logic [PA_WIDTH-1:0]             o_mem_addr,
  output logic [REG_WIDTH-1:0]            o_mem_wdata,
  input  logic                            i_mem_ack,
  input  logic [REG_WIDTH-1:0]            i_mem_rdata,
  input  logic                            i_mem_err,
  output logic                            o_fill_valid,
  output logic [PA_WIDTH-1:0]             o_fill_addr,
  output logic [LINE_WIDTH*REG_WIDTH-1:0] o_fill_data,
  output logic                            o_exeption
);

  localparam int WB = REG_WIDTH / 8;
  localparam int LB = LINE_WIDTH * WB;
  localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [PA_WIDTH-1:0] OFF_MASK = PA_WIDTH'(LB - 1);
  localparam logic [CW-1:0]       LAST     = CW'(LINE_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, WRBACK, FETCH, RESPOND} state_t;

  state_t                          state, state_nxt;
  logic [CW-1:0]                   cnt;
  logic [PA_WIDTH-1:0]             miss_base, evict_base, word_off;
  logic [LINE_WIDTH*REG_WIDTH-1:0] evict_line, line_buf;
  logic                            err_flag, last_word;

  assign last_word = (cnt == LAST);
  assign word_off  = PA_WIDTH'(cnt) * PA_WIDTH'(WB);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_miss) state_nxt = i_evict_dirty ? WRBACK : FETCH;
      WRBACK:  if (i_mem_ack) begin
                 if (i_mem_err)      state_nxt = RESPOND;
                 else if (last_word) state_nxt = FETCH;
               end
      FETCH:   if (i_mem_ack && (i_mem_err || last_word)) state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter, captured request and line buffer; acks are only honoured in the
  // states that issue a request, so a stray ack in IDLE is harmless.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      err_flag   <= 1'b0;
      miss_base  <= '0;
      evict_base <= '0;
      evict_line <= '0;
      line_buf   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (i_miss) begin
            miss_base  <= i_miss_addr & ~OFF_MASK;
            evict_base <= i_evict_addr & ~OFF_MASK;
            evict_line <= i_evict_data;
            err_flag   <= 1'b0;
          end
        end
        WRBACK: if (i_mem_ack) begin
          if (i_mem_err)      err_flag <= 1'b1;
          else if (last_word) cnt <= '0;
          else                cnt <= cnt + CW'(1);
        end
        FETCH: if (i_mem_ack) begin
          if (i_mem_err) begin
            err_flag <= 1'b1;
            line_buf <= '0;
          end else begin
            line_buf[int'(cnt)*REG_WIDTH +: REG_WIDTH] <= i_mem_rdata;
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_stall      = 1'b0;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_fill_valid = 1'b0;
    o_fill_addr  = '0;
    o_fill_data  = '0;
    o_exeption   = 1'b0;
    case (state)
      WRBACK: begin
        o_stall     = 1'b1;
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = evict_base + word_off;
        o_mem_wdata = evict_line[int'(cnt)*REG_WIDTH +: REG_WIDTH];
      end
      FETCH: begin
        o_stall    = 1'b1;
        o_mem_req  = 1'b1;
        o_mem_addr = miss_base + word_off;
      end
      RESPOND: begin
        o_stall = 1'b1;
        if (err_flag) begin
          o_exeption = 1'b1;
        end else begin
          o_fill_valid = 1'b1;
          o_fill_addr  = miss_base;
          o_fill_data  = line_buf;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dca_refill.sv
// Scoreboard bench for dca_refill: stimulus pushes expected memory ops and
// fill outcomes; a negedge monitor pops and compares what the DUT presents.
module tb_dca_refill;
  localparam int RW = 32;
  localparam int PW = 32;
  localparam int LW = 2;
  localparam int WB = RW / 8;
  localparam int LB = LW * WB;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           i_miss = 1'b0;
  logic [PW-1:0]  i_miss_addr = '0;
  logic           i_evict_dirty = 1'b0;
  logic [PW-1:0]  i_evict_addr = '0;
  logic [LW*RW-1:0] i_evict_data = '0;
  logic           o_stall, o_mem_req, o_mem_we;
  logic [PW-1:0]  o_mem_addr;
  logic [RW-1:0]  o_mem_wdata;
  logic           i_mem_ack = 1'b0;
  logic [RW-1:0]  i_mem_rdata = '0;
  logic           i_mem_err = 1'b0;
  logic           o_fill_valid;
  logic [PW-1:0]  o_fill_addr;
  logic [LW*RW-1:0] o_fill_data;
  logic           o_exeption;

  dca_refill #(.REG_WIDTH(RW), .PA_WIDTH(PW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .i_evict_dirty(i_evict_dirty), .i_evict_addr(i_evict_addr),
    .i_evict_data(i_evict_data), .o_stall(o_stall), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .i_mem_err(i_mem_err),
    .o_fill_valid(o_fill_valid), .o_fill_addr(o_fill_addr),
    .o_fill_data(o_fill_data), .o_exeption(o_exeption)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  typedef struct {
    logic          we;
    logic [PW-1:0] addr;
    logic [RW-1:0] wdata;
  } op_t;

  typedef struct {
    logic             err;
    logic [PW-1:0]    addr;
    logic [LW*RW-1:0] data;
    int               lat;
    int               acc;
  } fill_t;

  op_t   op_q[$];
  fill_t fill_q[$];

  // Memory model: preset words win, everything else is a fixed hash of the address.
  logic [RW-1:0] mem_pre [logic [PW-1:0]];
  function automatic logic [RW-1:0] mem_rd(input logic [PW-1:0] a);
    if (mem_pre.exists(a)) return mem_pre[a];
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  int            fixed_wait = 0;
  int            wait_left = 0;
  logic          bad_en = 1'b0;
  logic          bad_we = 1'b0;
  logic [PW-1:0] bad_addr = '0;
  logic          force_ack = 1'b0;

  function automatic int next_wait();
    if (fixed_wait >= 0) return fixed_wait;
    return int'($urandom_range(0, 3));
  endfunction

  // Memory responder: drives 1 time unit after each edge.
  always @(posedge clk) begin
    #1;
    i_mem_ack   = 1'b0;
    i_mem_err   = 1'b0;
    i_mem_rdata = $urandom;
    if (force_ack) begin
      i_mem_ack = 1'b1;
    end else if (rst && o_mem_req) begin
      if (wait_left > 0) begin
        wait_left--;
      end else begin
        i_mem_ack = 1'b1;
        if (!o_mem_we) i_mem_rdata = mem_rd(o_mem_addr);
        i_mem_err = bad_en && (o_mem_we == bad_we) && (o_mem_addr == bad_addr);
        wait_left = next_wait();
      end
    end
  end

  // Reference model: line bases by plain arithmetic, writes then reads,
  // stopping at the first errored word.
  task automatic expect_txn(input logic [PW-1:0] addr, input logic dirty,
                            input logic [PW-1:0] eaddr, input logic [LW*RW-1:0] edata,
                            input int acc);
    logic [PW-1:0]    mb, vb, a;
    logic [LW*RW-1:0] line;
    int               n;
    logic             e;
    op_t              o;
    fill_t            f;
    mb = addr - (addr % PW'(LB));
    vb = eaddr - (eaddr % PW'(LB));
    line = '0;
    n = 0;
    e = 1'b0;
    if (dirty) begin
      for (int k = 0; k < LW; k++) begin
        a = vb + PW'(k * WB);
        o.we = 1'b1; o.addr = a; o.wdata = edata[k*RW +: RW];
        op_q.push_back(o);
        n++;
        if (bad_en && bad_we && a == bad_addr) begin e = 1'b1; break; end
      end
    end
    if (!e) begin
      for (int k = 0; k < LW; k++) begin
        a = mb + PW'(k * WB);
        o.we = 1'b0; o.addr = a; o.wdata = '0;
        op_q.push_back(o);
        n++;
        if (bad_en && !bad_we && a == bad_addr) begin e = 1'b1; break; end
        line[k*RW +: RW] = mem_rd(a);
      end
    end
    f.err  = e;
    f.addr = e ? '0 : mb;
    f.data = e ? '0 : line;
    f.lat  = (fixed_wait >= 0) ? n * (fixed_wait + 1) + 1 : -1;
    f.acc  = acc;
    fill_q.push_back(f);
  endtask

  // Monitor
  logic  pend = 1'b0;
  logic  after_pulse = 1'b0;
  op_t   prev, mo;
  fill_t mf;

  always @(negedge clk) begin
    if (after_pulse) chk("idle_after_pulse", o_stall, 1'b0);
    after_pulse = 1'b0;
    if (rst) begin
      if (pend) begin
        chk("hold_req", o_mem_req, 1'b1);
        chk("hold_we", o_mem_we, prev.we);
        chk("hold_addr", o_mem_addr, prev.addr);
        chk("hold_wdata", o_mem_wdata, prev.wdata);
      end
      if (o_mem_req) chk("stall_with_req", o_stall, 1'b1);
      if (o_mem_req && i_mem_ack) begin
        if (op_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_mem_op: got we=%0b addr=%h, expected none", o_mem_we, o_mem_addr);
        end else begin
          mo = op_q.pop_front();
          chk("mem_we", o_mem_we, mo.we);
          chk("mem_addr", o_mem_addr, mo.addr);
          if (mo.we) chk("mem_wdata", o_mem_wdata, mo.wdata);
        end
      end
      if (o_fill_valid || o_exeption) begin
        chk("pulse_exclusive", o_fill_valid & o_exeption, 1'b0);
        chk("stall_in_respond", o_stall, 1'b1);
        if (fill_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pulse: got fill=%0b exc=%0b, expected none", o_fill_valid, o_exeption);
        end else begin
          mf = fill_q.pop_front();
          chk("exeption", o_exeption, mf.err);
          chk("fill_valid", o_fill_valid, !mf.err);
          chk("fill_addr", o_fill_addr, mf.addr);
          chk("fill_data", o_fill_data, mf.data);
          if (mf.lat >= 0) chk("latency", 64'(cyc - mf.acc + 1), 64'(mf.lat));
        end
        after_pulse = 1'b1;
      end
    end
    pend = rst && o_mem_req && !i_mem_ack;
    prev.we = o_mem_we; prev.addr = o_mem_addr; prev.wdata = o_mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_stall && n < 200) begin tick(); n++; end
    if (o_stall) begin
      checks++;
      $display("FAIL wait_idle: got stall=1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic drive_miss(input logic [PW-1:0] addr, input logic dirty,
                            input logic [PW-1:0] eaddr, input logic [LW*RW-1:0] edata);
    i_miss = 1'b1; i_miss_addr = addr; i_evict_dirty = dirty;
    i_evict_addr = eaddr; i_evict_data = edata;
  endtask

  task automatic do_miss(input logic [PW-1:0] addr, input logic dirty,
                         input logic [PW-1:0] eaddr, input logic [LW*RW-1:0] edata);
    wait_idle();
    wait_left = next_wait();
    drive_miss(addr, dirty, eaddr, edata);
    expect_txn(addr, dirty, eaddr, edata, cyc + 1);
    tick();
    i_miss = 1'b0;
    i_miss_addr = $urandom; i_evict_addr = $urandom; i_evict_dirty = 1'b0;
    i_evict_data = {$urandom, $urandom};
    wait_idle();
    bad_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, o_stall, 1'b0);
    chk({tag, "_req"}, o_mem_req, 1'b0);
    chk({tag, "_we"}, o_mem_we, 1'b0);
    chk({tag, "_addr"}, o_mem_addr, '0);
    chk({tag, "_wdata"}, o_mem_wdata, '0);
    chk({tag, "_fill_valid"}, o_fill_valid, 1'b0);
    chk({tag, "_fill_addr"}, o_fill_addr, '0);
    chk({tag, "_fill_data"}, o_fill_data, '0);
    chk({tag, "_exeption"}, o_exeption, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int n, sz;
    logic d;
    tick(); tick(); tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();

    // 1: clean miss, 0-wait, preset data
    mem_pre[32'h10] = 32'hA;
    mem_pre[32'h14] = 32'hB;
    fixed_wait = 0;
    do_miss(32'h14, 1'b0, 32'h0, '0);

    // 2: dirty miss, 0-wait
    do_miss(32'h08, 1'b1, 32'h24, {32'h2, 32'h1});

    // 3: three wait cycles per word, clean and dirty
    fixed_wait = 3;
    do_miss(32'h14, 1'b0, 32'h0, '0);
    do_miss(32'h1234_5678, 1'b1, 32'h8765_4321, {32'hDEAD_BEEF, 32'hCAFE_F00D});

    // 4: bus error on second fetch word, then a normal miss
    fixed_wait = 0;
    bad_en = 1'b1; bad_we = 1'b0; bad_addr = 32'h104;
    do_miss(32'h100, 1'b0, 32'h0, '0);
    do_miss(32'h200, 1'b0, 32'h0, '0);
    bad_en = 1'b1; bad_we = 1'b1; bad_addr = 32'h300;
    do_miss(32'h400, 1'b1, 32'h304, {32'h33, 32'h44});

    // 5: reset mid-FETCH after one ack, then a late ack in IDLE
    fixed_wait = 1;
    wait_idle();
    wait_left = next_wait();
    drive_miss(32'h500, 1'b0, 32'h0, '0);
    expect_txn(32'h500, 1'b0, 32'h0, '0, cyc + 1);
    sz = op_q.size();
    tick();
    i_miss = 1'b0;
    n = 0;
    while (op_q.size() == sz && n < 20) begin tick(); n++; end
    chk("one_ack_before_reset", 64'(op_q.size()), 64'(sz - 1));
    rst = 1'b0;
    op_q.delete();
    fill_q.delete();
    tick();
    chk_all_zero("mid_reset");
    rst = 1'b1;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick(); tick();
    chk("late_ack_stall", o_stall, 1'b0);
    chk("late_ack_req", o_mem_req, 1'b0);
    do_miss(32'h600, 1'b0, 32'h0, '0);

    // 6: i_miss held across RESPOND, plus a busy-time pulse that must not queue
    fixed_wait = 0;
    wait_idle();
    wait_left = next_wait();
    drive_miss(32'h700, 1'b0, 32'h0, '0);
    expect_txn(32'h700, 1'b0, 32'h0, '0, cyc + 1);
    tick();
    n = 0;
    while (!o_fill_valid && n < 20) begin tick(); n++; end
    expect_txn(32'h700, 1'b0, 32'h0, '0, cyc + 2);
    tick();
    chk("idle_between", o_stall, 1'b0);
    tick();
    chk("second_started", o_stall, 1'b1);
    tick();
    i_miss = 1'b0;
    tick();
    i_miss = 1'b1;
    tick();
    i_miss = 1'b0;
    wait_idle();

    // Random traffic with random waits and occasional bus errors
    fixed_wait = -1;
    for (int t = 0; t < 40; t++) begin
      logic [PW-1:0]    ma, ea;
      logic [LW*RW-1:0] ed;
      ma = $urandom; ea = $urandom; ed = {$urandom, $urandom};
      d = 1'($urandom_range(0, 1));
      bad_en = ($urandom_range(0, 4) == 0);
      bad_we = d && 1'($urandom_range(0, 1));
      bad_addr = (bad_we ? (ea - (ea % PW'(LB))) : (ma - (ma % PW'(LB))))
                 + PW'($urandom_range(0, LW - 1) * WB);
      do_miss(ma, d, ea, ed);
    end

    tick(); tick();
    chk("ops_drained", 64'(op_q.size()), 64'd0);
    chk("fills_drained", 64'(fill_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
